// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// and the iteration-counter width derived from the operand width.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_WIDTH = 32;

  function automatic int mdu_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu.sv
// Iterative HI/LO multiply/divide unit: one shared adder runs a radix-2
// shift-add multiply or a restoring divide, one bit per cycle, WIDTH cycles.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUop,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = mdu_cnt_w(WIDTH);
  localparam int AW = WIDTH + 2;

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic             div0_q, div0_d, busy_q, busy_d;

  mdu_op_e          op;
  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]    add_x, add_y, add_sum;
  logic             add_sub, ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  assign op        = mdu_op_e'(MDUop);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = signed_op & A[WIDTH-1];
  assign sb        = signed_op & B[WIDTH-1];
  assign a_mag     = sa ? -A : A;
  assign b_mag     = sb ? -B : B;

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts out.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and
  // quotient bits in.
  always_comb begin
    if (is_div_q) begin
      add_x   = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]};
      add_y   = {2'b00, opnd_q};
      add_sub = 1'b1;
    end else begin
      add_x   = {2'b00, acc_hi_q};
      add_y   = acc_lo_q[0] ? {2'b00, opnd_q} : '0;
      add_sub = 1'b0;
    end
    add_sum = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);
    ge      = ~add_sum[AW-1];
    if (is_div_q) begin
      step_hi = ge ? add_sum[WIDTH-1:0] : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
      step_lo = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = {step_hi, step_lo};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (op)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = S_RUN;
              busy_d   = 1'b1;
              cnt_d    = '0;
              is_div_d = (op == OP_DIV) || (op == OP_DIVU);
              acc_hi_d = '0;
              acc_lo_d = is_div_d ? a_mag : b_mag;
              opnd_d   = is_div_d ? b_mag : a_mag;
              neg_q_d  = sa ^ sb;
              neg_r_d  = sa;
              div0_d   = (B == '0);
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : (neg_q_q ? -step_lo : step_lo);
            hi_d = neg_r_q ? -step_hi : step_hi;
          end else begin
            {hi_d, lo_d} = neg_q_q ? -prod : prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a vector table of iterative ops run back-to-back,
// plus hand sequences for MTHI/MTLO, ignored starts and mid-op reset.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  MDUop;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    bit         inj;
  } vec_t;

  vec_t vecs[12];

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .MDUop(MDUop), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_iter(input vec_t v);
    int  n;
    bit  held;
    Start = 1'b1; MDUop = v.op; A = v.a; B = v.b;
    @(posedge clk); #1;
    Start = 1'b0; MDUop = NOP;
    n = 0; held = 1'b1;
    while (Busy && n < 64) begin
      if (HI !== m_hi || LO !== m_lo) held = 1'b0;
      if (v.inj && n == 3) begin
        Start = 1'b1; MDUop = MTLO; A = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0; MDUop = NOP;
      end
      @(posedge clk); #1;
      n++;
    end
    Start = 1'b0; MDUop = NOP;
    check({v.name, " busy_cycles"}, 64'(n), 64'd32);
    check({v.name, " hold"}, 64'(held), 64'd1);
    check({v.name, " HI"}, 64'(HI), 64'(v.hi));
    check({v.name, " LO"}, 64'(LO), 64'(v.lo));
    m_hi = v.hi; m_lo = v.lo;
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; MDUop = op; A = a;
    @(posedge clk); #1;
    Start = 1'b0; MDUop = NOP;
  endtask

  initial begin
    vecs[0]  = '{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    vecs[1]  = '{"mult_neg",   MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{"div_neg",    DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"divu_7_2",   DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{"div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"divu_zero",  DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"div_zero",   DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{"mult_minsq", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{"multu_x16",  MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b1};
    vecs[9]  = '{"div_negdiv", DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{"mult_m1",    MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[11] = '{"divu_big",   DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    rst = 1'b1; Start = 1'b0; MDUop = NOP; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    check("reset Busy", 64'(Busy), 64'd0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;

    // Vectors issue back-to-back: each Start lands in the cycle after Busy falls.
    for (int i = 0; i < 12; i++) run_iter(vecs[i]);

    // MTLO then MTHI: each updates only its own register, never busy
    move(MTLO, 32'h00000009);
    check("mtlo Busy", 64'(Busy), 64'd0);
    check("mtlo LO", 64'(LO), 64'h9);
    check("mtlo HI kept", 64'(HI), 64'(m_hi));
    move(MTHI, 32'h12345678);
    check("mthi Busy", 64'(Busy), 64'd0);
    check("mthi HI", 64'(HI), 64'h12345678);
    check("mthi LO kept", 64'(LO), 64'h9);
    m_hi = 32'h12345678; m_lo = 32'h9;

    // MULTU at cycle 0, MTHI at 5 (ignored), reset at 10 aborts.
    Start = 1'b1; MDUop = MULTU; A = 32'hFFFFFFFF; B = 32'h3;
    @(posedge clk); #1;
    Start = 1'b0; MDUop = NOP;
    check("abort Busy started", 64'(Busy), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    Start = 1'b1; MDUop = MTHI; A = 32'h55;
    @(posedge clk); #1;
    Start = 1'b0; MDUop = NOP;
    check("ignored mthi HI", 64'(HI), 64'(m_hi));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; Start = 1'b1; MDUop = MTLO; A = 32'hAAAA5555;
    @(posedge clk); #1;
    rst = 1'b0; Start = 1'b0; MDUop = NOP;
    check("abort HI", 64'(HI), 64'd0);
    check("abort LO", 64'(LO), 64'd0);
    check("abort Busy", 64'(Busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort no late HI", 64'(HI), 64'd0);
    check("abort no late LO", 64'(LO), 64'd0);
    check("abort no late Busy", 64'(Busy), 64'd0);
    m_hi = '0; m_lo = '0;

    // Operation right after reset still works.
    run_iter(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
